pong_graph_animate: RTL and testbench

//  Parametrised, animated successor to the static wall/ball/paddle pixel generator.

---
 rtl/pong_pkg.sv | 25 ++
 rtl/pong_ball_rom.sv | 39 +++
 rtl/pong_graph_animate.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_pong_graph_animate.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// ---------------------------------------------------------------------------
// pong_pkg
//   Shared types and constants for the animated pong pixel generator.
//   - pong_state_e : ball FSM states (SERVE, PLAY, MISS)
//   - COL_*        : colour constants held as one enable bit per channel
//                    {R,G,B}. The top expands each bit to a full-scale field
//                    of RGB_W/3 bits, so one set of constants serves any RGB_W.
// ---------------------------------------------------------------------------
package pong_pkg;

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    PLAY  = 2'd1,
    MISS  = 2'd2
  } pong_state_e;

  typedef logic [2:0] pong_col_t;

  localparam pong_col_t COL_BLACK = 3'b000;
  localparam pong_col_t COL_WALL  = 3'b001;  // blue
  localparam pong_col_t COL_BALL  = 3'b100;  // red
  localparam pong_col_t COL_PAD   = 3'b010;  // green
  localparam pong_col_t COL_BG    = 3'b111;  // white

endpackage

// File: rtl/pong_ball_rom.sv
// ---------------------------------------------------------------------------
// pong_ball_rom
//   Combinational 8x8 round-ball bitmap. Used only when the design is built
//   with PONG_ROUND_BALL_EN defined; the body is guarded by the same macro so
//   the default build carries no orphan module.
//   Ports:
//     row_i [2:0]  bitmap row    (pixel_y - ball_y)
//     col_i [2:0]  bitmap column (pixel_x - ball_x)
//     bit_o        1 when the pixel belongs to the round ball
// ---------------------------------------------------------------------------
`ifdef PONG_ROUND_BALL_EN
module pong_ball_rom (
  input  logic [2:0] row_i,
  input  logic [2:0] col_i,
  output logic       bit_o
);

  logic [7:0] row_bits;

  always_comb begin
    row_bits = 8'b0000_0000;
    unique case (row_i)
      3'd0:    row_bits = 8'b0011_1100;
      3'd1:    row_bits = 8'b0111_1110;
      3'd2:    row_bits = 8'b1111_1111;
      3'd3:    row_bits = 8'b1111_1111;
      3'd4:    row_bits = 8'b1111_1111;
      3'd5:    row_bits = 8'b1111_1111;
      3'd6:    row_bits = 8'b0111_1110;
      3'd7:    row_bits = 8'b0011_1100;
      default: row_bits = 8'b0000_0000;
    endcase
  end

  // Bitmap is left/right symmetric, so bit order within a row is immaterial.
  assign bit_o = row_bits[col_i];

endmodule
`endif

// File: rtl/pong_graph_animate.sv
// ---------------------------------------------------------------------------
// pong_graph_animate
//   Animated wall / ball / paddle pixel generator. Sits between the VGA sync
//   timing block and the DAC. Motion updates once per frame on the refresh
//   tick (pixel_x == 0 && pixel_y == V_PIXELS); the colour output is
//   registered, one clk behind pixel_x/pixel_y.
//
//   Build option: PONG_ROUND_BALL_EN -- when defined, the ball is drawn
//   through an 8x8 round bitmap (BALL_SIZE must be 8). Collision always uses
//   the square bounding box.
//
//   Ports:
//     clk            pixel clock
//     reset          synchronous, active-high
//     pixel_x/_y     current scan position (COORD_W)
//     video_on       high in the visible region
//     btn_up/_down   debounced paddle buttons (level)
//     rgb            registered colour (RGB_W, fields R,G,B)
//     hit            one-clk pulse: ball struck paddle
//     miss           one-clk pulse: ball passed the paddle
//     dbg_state_o    FSM state (pong_state_e encoding)
//     dbg_ball_x_o   ball left column
//     dbg_ball_y_o   ball top line
//     dbg_pad_top_o  paddle top line
// ---------------------------------------------------------------------------
module pong_graph_animate
  import pong_pkg::*;
#(
  parameter int COORD_W      = 10,
  parameter int RGB_W        = 12,
  parameter int H_PIXELS     = 640,
  parameter int V_PIXELS     = 480,
  parameter int WALL_X_L     = 32,
  parameter int WALL_X_R     = 35,
  parameter int PAD_X_L      = 600,
  parameter int PAD_X_R      = 603,
  parameter int PAD_H        = 72,
  parameter int PAD_V        = 4,
  parameter int BALL_SIZE    = 8,
  parameter int BALL_V       = 2,
  parameter int SERVE_FRAMES = 60
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] pixel_x,
  input  logic [COORD_W-1:0] pixel_y,
  input  logic               video_on,
  input  logic               btn_up,
  input  logic               btn_down,
  output logic [RGB_W-1:0]   rgb,
  output logic               hit,
  output logic               miss,
  output logic [1:0]         dbg_state_o,
  output logic [COORD_W-1:0] dbg_ball_x_o,
  output logic [COORD_W-1:0] dbg_ball_y_o,
  output logic [COORD_W-1:0] dbg_pad_top_o
);

  // One extra bit so edge sums never wrap and signed next positions can
  // show underflow before clamping.
  localparam int SW    = COORD_W + 1;
  localparam int FW    = RGB_W / 3;
  localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

  localparam logic [COORD_W-1:0] X_CENTRE    = COORD_W'(H_PIXELS / 2);
  localparam logic [COORD_W-1:0] Y_CENTRE    = COORD_W'(V_PIXELS / 2);
  localparam logic [COORD_W-1:0] PAD_TOP_RST = COORD_W'((V_PIXELS - PAD_H) / 2);
  localparam logic [COORD_W-1:0] PAD_TOP_MAX = COORD_W'(V_PIXELS - PAD_H);
  localparam logic [COORD_W-1:0] PAD_STEP    = COORD_W'(PAD_V);
  localparam logic [COORD_W-1:0] BALL_STEP   = COORD_W'(BALL_V);
  localparam logic [CNT_W-1:0]   SERVE_LAST  = CNT_W'(SERVE_FRAMES - 1);

  localparam logic signed [SW-1:0] BALL_STEP_S = SW'(BALL_V);
  localparam logic signed [SW-1:0] X_LIM_S     = SW'(H_PIXELS - BALL_SIZE);
  localparam logic signed [SW-1:0] Y_LIM_S     = SW'(V_PIXELS - BALL_SIZE);

  localparam logic [SW-1:0] BALL_EXT = SW'(BALL_SIZE - 1);
  localparam logic [SW-1:0] PAD_EXT  = SW'(PAD_H - 1);
  localparam logic [SW-1:0] Y_BOUNCE = SW'(V_PIXELS - 1 - BALL_V);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  pong_state_e        state_q, state_d;
  logic [CNT_W-1:0]   serve_cnt_q, serve_cnt_d;
  logic [COORD_W-1:0] ball_x_q, ball_x_d;
  logic [COORD_W-1:0] ball_y_q, ball_y_d;
  logic               dx_neg_q, dx_neg_d;   // direction only; magnitude is BALL_V
  logic               dy_neg_q, dy_neg_d;
  logic [COORD_W-1:0] pad_top_q, pad_top_d;
  logic               hit_q, hit_d;
  logic               miss_q, miss_d;
  logic [RGB_W-1:0]   rgb_q, rgb_d;

  logic tick;
  assign tick = (pixel_x == '0) && (pixel_y == COORD_W'(V_PIXELS));

  // ---------------------------------------------------------------------
  // Widened geometry
  // ---------------------------------------------------------------------
  logic [SW-1:0] ball_l_w, ball_r_w, ball_t_w, ball_b_w;
  logic [SW-1:0] pad_t_w, pad_b_w, px_w, py_w;

  assign ball_l_w = {1'b0, ball_x_q};
  assign ball_r_w = ball_l_w + BALL_EXT;
  assign ball_t_w = {1'b0, ball_y_q};
  assign ball_b_w = ball_t_w + BALL_EXT;
  assign pad_t_w  = {1'b0, pad_top_q};
  assign pad_b_w  = pad_t_w + PAD_EXT;
  assign px_w     = {1'b0, pixel_x};
  assign py_w     = {1'b0, pixel_y};

  logic pad_y_overlap, pad_hit, ball_past;

  assign pad_y_overlap = (ball_t_w <= pad_b_w) && (ball_b_w >= pad_t_w);
  assign pad_hit   = !dx_neg_q
                     && (ball_r_w >= SW'(PAD_X_L)) && (ball_r_w <= SW'(PAD_X_R))
                     && pad_y_overlap;
  assign ball_past = ball_r_w > SW'(PAD_X_R);

  // ---------------------------------------------------------------------
  // Motion / FSM next state
  // ---------------------------------------------------------------------
  logic signed [SW-1:0] dx_s, dy_s, nx_s, ny_s;

  always_comb begin
    state_d     = state_q;
    serve_cnt_d = serve_cnt_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    dx_neg_d    = dx_neg_q;
    dy_neg_d    = dy_neg_q;
    pad_top_d   = pad_top_q;
    hit_d       = 1'b0;
    miss_d      = 1'b0;
    dx_s        = '0;
    dy_s        = '0;
    nx_s        = '0;
    ny_s        = '0;

    if (tick) begin
      // Paddle: opposing buttons cancel.
      if (btn_up && !btn_down) begin
        if (pad_top_q < PAD_STEP) pad_top_d = '0;
        else                      pad_top_d = pad_top_q - PAD_STEP;
      end else if (btn_down && !btn_up) begin
        if (pad_top_q > PAD_TOP_MAX - PAD_STEP) pad_top_d = PAD_TOP_MAX;
        else                                     pad_top_d = pad_top_q + PAD_STEP;
      end

      unique case (state_q)
        SERVE: begin
          if (serve_cnt_q == SERVE_LAST) begin
            state_d     = PLAY;
            serve_cnt_d = '0;
          end else begin
            serve_cnt_d = serve_cnt_q + 1'b1;
          end
        end

        PLAY: begin
          // Vertical axis
          if (ball_y_q <= BALL_STEP)     dy_neg_d = 1'b0;
          else if (ball_b_w >= Y_BOUNCE) dy_neg_d = 1'b1;

          // Horizontal axis: wall, then paddle / miss
          if (ball_x_q <= COORD_W'(WALL_X_R)) dx_neg_d = 1'b0;
          if (pad_hit) begin
            dx_neg_d = 1'b1;
            hit_d    = 1'b1;
          end else if (ball_past) begin
            state_d = MISS;
            miss_d  = 1'b1;
          end

          // Move with the freshly decided directions, then clamp.
          dx_s = dx_neg_d ? -BALL_STEP_S : BALL_STEP_S;
          dy_s = dy_neg_d ? -BALL_STEP_S : BALL_STEP_S;
          nx_s = signed'(ball_l_w) + dx_s;
          ny_s = signed'(ball_t_w) + dy_s;

          if (nx_s[SW-1])        ball_x_d = '0;
          else if (nx_s > X_LIM_S) ball_x_d = X_LIM_S[COORD_W-1:0];
          else                   ball_x_d = nx_s[COORD_W-1:0];

          if (ny_s[SW-1])        ball_y_d = '0;
          else if (ny_s > Y_LIM_S) ball_y_d = Y_LIM_S[COORD_W-1:0];
          else                   ball_y_d = ny_s[COORD_W-1:0];
        end

        MISS: begin
          ball_x_d    = X_CENTRE;
          ball_y_d    = Y_CENTRE;
          dx_neg_d    = 1'b0;
          dy_neg_d    = 1'b0;
          serve_cnt_d = '0;
          state_d     = SERVE;
        end

        default: state_d = SERVE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Render
  // ---------------------------------------------------------------------
  logic in_wall, in_ball_box, in_ball, in_pad;
  pong_col_t col_sel;

  assign in_wall     = (px_w >= SW'(WALL_X_L)) && (px_w <= SW'(WALL_X_R));
  assign in_ball_box = (px_w >= ball_l_w) && (px_w <= ball_r_w)
                       && (py_w >= ball_t_w) && (py_w <= ball_b_w);
  assign in_pad      = (px_w >= SW'(PAD_X_L)) && (px_w <= SW'(PAD_X_R))
                       && (py_w >= pad_t_w) && (py_w <= pad_b_w);

`ifdef PONG_ROUND_BALL_EN
  logic [2:0] rom_row, rom_col;
  logic       rom_bit;

  // Low three bits of the offset are enough inside an 8-pixel box.
  assign rom_row = pixel_y[2:0] - ball_y_q[2:0];
  assign rom_col = pixel_x[2:0] - ball_x_q[2:0];

  pong_ball_rom u_ball_rom (
    .row_i (rom_row),
    .col_i (rom_col),
    .bit_o (rom_bit)
  );

  assign in_ball = in_ball_box && rom_bit;
`else
  assign in_ball = in_ball_box;
`endif

  always_comb begin
    col_sel = COL_BLACK;
    if (!video_on)    col_sel = COL_BLACK;
    else if (in_wall) col_sel = COL_WALL;
    else if (in_ball) col_sel = COL_BALL;
    else if (in_pad)  col_sel = COL_PAD;
    else              col_sel = COL_BG;
    rgb_d = {{FW{col_sel[2]}}, {FW{col_sel[1]}}, {FW{col_sel[0]}}};
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SERVE;
      serve_cnt_q <= '0;
      ball_x_q    <= X_CENTRE;
      ball_y_q    <= Y_CENTRE;
      dx_neg_q    <= 1'b0;
      dy_neg_q    <= 1'b0;
      pad_top_q   <= PAD_TOP_RST;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      rgb_q       <= '0;
    end else begin
      state_q     <= state_d;
      serve_cnt_q <= serve_cnt_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      dx_neg_q    <= dx_neg_d;
      dy_neg_q    <= dy_neg_d;
      pad_top_q   <= pad_top_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      rgb_q       <= rgb_d;
    end
  end

  assign rgb           = rgb_q;
  assign hit           = hit_q;
  assign miss          = miss_q;
  assign dbg_state_o   = state_q;
  assign dbg_ball_x_o  = ball_x_q;
  assign dbg_ball_y_o  = ball_y_q;
  assign dbg_pad_top_o = pad_top_q;

endmodule

// File: tb/tb_pong_graph_animate.sv
// ---------------------------------------------------------------------------
// tb_pong_graph_animate
//   Directed bench for pong_graph_animate with hand-computed expectations.
//   Frame ticks are produced by presenting (0, 480) for one clk.
// ---------------------------------------------------------------------------
module tb_pong_graph_animate;

  localparam logic [1:0] ST_SERVE = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_MISS  = 2'd2;

  logic        clk;
  logic        reset;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        video_on;
  logic        btn_up;
  logic        btn_down;
  logic [11:0] rgb;
  logic        hit;
  logic        miss;
  logic [1:0]  dbg_state;
  logic [9:0]  dbg_ball_x;
  logic [9:0]  dbg_ball_y;
  logic [9:0]  dbg_pad_top;

  pong_graph_animate dut (
    .clk           (clk),
    .reset         (reset),
    .pixel_x       (pixel_x),
    .pixel_y       (pixel_y),
    .video_on      (video_on),
    .btn_up        (btn_up),
    .btn_down      (btn_down),
    .rgb           (rgb),
    .hit           (hit),
    .miss          (miss),
    .dbg_state_o   (dbg_state),
    .dbg_ball_x_o  (dbg_ball_x),
    .dbg_ball_y_o  (dbg_ball_y),
    .dbg_pad_top_o (dbg_pad_top)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // ---------------- drivers ----------------
  int   hit_cnt  = 0;
  int   miss_cnt = 0;
  logic tick_hit;
  logic tick_miss;

  task automatic do_tick();
    @(negedge clk);
    pixel_x = 10'd0;
    pixel_y = 10'd480;
    @(negedge clk);
    tick_hit  = hit;
    tick_miss = miss;
    if (hit)  hit_cnt++;
    if (miss) miss_cnt++;
    pixel_x = 10'd100;
    pixel_y = 10'd100;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic check_ball(input string tag, input int x, input int y);
    check_eq({tag, "_x"}, 32'(dbg_ball_x), 32'(x));
    check_eq({tag, "_y"}, 32'(dbg_ball_y), 32'(y));
  endtask

  // Render vectors: x, y, video_on, expected rgb
  int rx [5] = '{33, 601, 320, 100, 320};
  int ry [5] = '{100, 210, 240, 100, 240};
  int rv [5] = '{1, 1, 1, 1, 0};
  int rc [5] = '{'h00F, 'h0F0, 'hF00, 'hFFF, 'h000};

  initial begin
    reset    = 1'b1;
    pixel_x  = 10'd100;
    pixel_y  = 10'd100;
    video_on = 1'b1;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    tick_hit  = 1'b0;
    tick_miss = 1'b0;

    // Reset: two clks asserted.
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_eq("rst_rgb",   32'(rgb),         32'h0);
    check_eq("rst_hit",   32'(hit),         32'h0);
    check_eq("rst_miss",  32'(miss),        32'h0);
    check_eq("rst_state", 32'(dbg_state),   32'(ST_SERVE));
    check_eq("rst_pad",   32'(dbg_pad_top), 32'd204);
    check_ball("rst_ball", 320, 240);

    // Render: one clk latency.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pixel_x  = 10'(rx[i]);
      pixel_y  = 10'(ry[i]);
      video_on = rv[i][0];
      exp_q.push_back(32'(rc[i]));
      @(negedge clk);
      check_eq($sformatf("render%0d", i), 32'(rgb), exp_q.pop_front());
    end
    video_on = 1'b1;
    pixel_x  = 10'd100;
    pixel_y  = 10'd100;

    // Serve with btn_up held: paddle clamps after 51 ticks.
    btn_up = 1'b1;
    run_ticks(51);
    check_eq("pad_at_51", 32'(dbg_pad_top), 32'd0);
    run_ticks(8);
    check_eq("serve_59", 32'(dbg_state), 32'(ST_SERVE));
    run_ticks(1);
    check_eq("serve_60", 32'(dbg_state), 32'(ST_PLAY));
    check_eq("pad_at_60", 32'(dbg_pad_top), 32'd0);
    check_ball("serve_ball", 320, 240);
    repeat (5) @(negedge clk);
    check_ball("idle_hold", 320, 240);

    // Play tick 1 with both buttons: paddle holds, ball moves.
    btn_down = 1'b1;
    run_ticks(1);
    check_eq("pad_both", 32'(dbg_pad_top), 32'd0);
    check_ball("play1", 322, 242);

    // Paddle descends to its floor; ball runs to the bottom edge.
    btn_up = 1'b0;
    run_ticks(114);
    check_ball("play115", 550, 470);
    run_ticks(1);
    check_ball("bounce_bot", 552, 468);
    run_ticks(21);
    check_ball("play137", 594, 426);
    check_eq("pad_floor", 32'(dbg_pad_top), 32'd408);
    check_eq("no_hit_yet", 32'(hit_cnt), 32'd0);

    // Paddle hit.
    run_ticks(1);
    check_eq("hit_pulse", 32'(tick_hit), 32'd1);
    check_ball("after_hit", 592, 424);
    @(negedge clk);
    check_eq("hit_1clk", 32'(hit), 32'd0);

    // Back to the wall (top bounce on the way).
    run_ticks(279);
    check_ball("play417", 34, 138);
    run_ticks(1);
    check_ball("bounce_wall", 36, 140);

    // Paddle to the top; ball passes it.
    btn_down = 1'b0;
    btn_up   = 1'b1;
    run_ticks(281);
    check_ball("play699", 598, 238);
    check_eq("pad_top0", 32'(dbg_pad_top), 32'd0);
    check_eq("miss_none", 32'(miss_cnt), 32'd0);
    check_eq("hit_total", 32'(hit_cnt), 32'd1);
    run_ticks(1);
    check_eq("miss_pulse", 32'(tick_miss), 32'd1);
    check_eq("state_miss", 32'(dbg_state), 32'(ST_MISS));
    @(negedge clk);
    check_eq("miss_1clk", 32'(miss), 32'd0);
    run_ticks(1);
    check_eq("reserve_state", 32'(dbg_state), 32'(ST_SERVE));
    check_ball("reserve_ball", 320, 240);
    check_eq("miss_total", 32'(miss_cnt), 32'd1);

    // Serve again, play 3 ticks, then reset mid-play.
    btn_up   = 1'b0;
    btn_down = 1'b1;
    run_ticks(63);
    check_eq("replay_state", 32'(dbg_state), 32'(ST_PLAY));
    check_ball("replay3", 326, 246);
    check_eq("replay_pad", 32'(dbg_pad_top), 32'd252);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("mid_rst_state", 32'(dbg_state), 32'(ST_SERVE));
    check_eq("mid_rst_pad", 32'(dbg_pad_top), 32'd204);
    check_eq("mid_rst_rgb", 32'(rgb), 32'h0);
    check_ball("mid_rst_ball", 320, 240);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
